// File: rtl/chunked_adder_pkg.sv
// Shared types and elaboration helpers for the chunked adder.
package chunked_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of chunks resolved per operation.
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Width of the chunk index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunked_adder_chunk_add.sv
// Combinational W-bit ripple adder for one chunk. c_msb is the carry into
// the top bit, which the top level needs for signed overflow.
module chunk_add #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);

  logic [W:0] c;

  // Bit-serial ripple through the chunk.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: WIDTH bits resolved CHUNK bits per clock,
// with the inter-chunk carry held in a register.
//   state | meaning
//   IDLE  | waiting for operands, previous result held
//   RUN   | one chunk computed per clock
//   DONE  | result valid, waiting for the consumer
module chunked_adder
  import chunked_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int KW     = idx_width(NCHUNK);
  localparam logic [KW-1:0]    KLAST = KW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MASK  = WIDTH'({CHUNK{1'b1}});

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("chunked_adder: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             cout_r;
  logic             ovf_r;
  logic [KW-1:0]    k;

  logic [31:0]      sh;
  logic [CHUNK-1:0] a_k;
  logic [CHUNK-1:0] b_k;
  logic [CHUNK-1:0] s_k;
  logic             co_k;
  logic             cmsb_k;
  logic [WIDTH-1:0] sum_next;

  // Select the active chunk of each operand by shifting it down to bit 0.
  assign sh  = 32'(k) * 32'(CHUNK);
  assign a_k = CHUNK'(a_r >> sh);
  assign b_k = CHUNK'(b_r >> sh);

  chunk_add #(.W(CHUNK)) u_chunk_add (
    .a     (a_k),
    .b     (b_k),
    .ci    (carry_r),
    .s     (s_k),
    .co    (co_k),
    .c_msb (cmsb_k)
  );

  // Splice the freshly computed chunk into the running result.
  assign sum_next = (sum_r & ~(MASK << sh)) | (WIDTH'(s_k) << sh);

  // Sequencer: latch operands, walk the chunks, hold the result for the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      k       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + ~borrow_in, so invert once here.
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub ? ~cin : cin;
            k       <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_r   <= sum_next;
          carry_r <= co_k;
          k       <= k + 1'b1;
          if (k == KLAST) begin
            cout_r <= co_k;
            ovf_r  <= cmsb_k ^ co_k;
            k      <= '0;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign overflow  = ovf_r;

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench: an arithmetic reference model plus a per-cycle compare
// process, for a CHUNK=4 instance and a CHUNK=WIDTH instance.
module tb_chunked_adder;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid0 = 1'b0;
  logic         in_valid1 = 1'b0;
  logic         out_ready = 1'b0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic         in_ready0, out_valid0, cout0, ovf0;
  logic [W-1:0] sum0;
  logic         in_ready1, out_valid1, cout1, ovf1;
  logic [W-1:0] sum1;

  int total = 0;
  int bad   = 0;
  logic [W+1:0] exp_res = '0;   // {overflow, cout, sum}

  chunked_adder #(.WIDTH(W), .CHUNK(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid0),
    .out_ready(out_ready), .sum(sum0), .cout(cout0), .overflow(ovf0)
  );

  chunked_adder #(.WIDTH(W), .CHUNK(W)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid1),
    .out_ready(out_ready), .sum(sum1), .cout(cout1), .overflow(ovf1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci, input logic sb);
    int ux, uy, sx, sy, ic, r, sr;
    logic co, ov;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    ic = ci ? 1 : 0;
    if (!sb) begin
      r  = ux + uy + ic;
      sr = sx + sy + ic;
      co = (r >= (1 << W));
    end else begin
      r  = ux - uy - ic;
      sr = sx - sy - ic;
      co = (ux >= uy + ic);
    end
    ov = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    return {ov, co, W'(r)};
  endfunction

  // Whenever a result is presented it must match the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid0) chk("result0", 32'({ovf0, cout0, sum0}), 32'(exp_res));
      if (out_valid1) chk("result1", 32'({ovf1, cout1, sum1}), 32'(exp_res));
    end
  end

  task automatic do_op(input bit inst, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic sb, input int hold, input bit early);
    int lat;
    int nch;
    nch = inst ? 1 : 4;
    @(negedge clk);
    a = x; b = y; cin = ci; sub = sb;
    out_ready = early;
    chk("in_ready_idle", 32'(inst ? in_ready1 : in_ready0), 32'd1);
    if (inst) in_valid1 = 1'b1; else in_valid0 = 1'b1;
    @(posedge clk);
    exp_res = ref_op(x, y, ci, sb);
    #1;
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!(inst ? out_valid1 : out_valid0) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(nch));
    if (!early) begin
      repeat (hold) begin
        @(negedge clk);
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        if (inst) in_valid1 = 1'b1; else in_valid0 = 1'b1;
        #1;
        chk("in_ready_stall", 32'(inst ? in_ready1 : in_ready0), 32'd0);
      end
      @(negedge clk);
      in_valid0 = 1'b0; in_valid1 = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("done_exit", 32'(inst ? {out_valid1, in_ready1} : {out_valid0, in_ready0}), 32'b01);
    out_ready = 1'b0;
    chk("held_idle", 32'(inst ? {ovf1, cout1, sum1} : {ovf0, cout0, sum0}), 32'(exp_res));
  endtask

  task automatic directed(input bit inst, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic sb, input logic [W+1:0] lit);
    do_op(inst, x, y, ci, sb, 1, 1'b0);
    chk("literal", 32'(inst ? {ovf1, cout1, sum1} : {ovf0, cout0, sum0}), 32'(lit));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state0", 32'({out_valid0, in_ready0, ovf0, cout0, sum0}), 32'({2'b01, 2'b00, 16'h0}));
    chk("rst_state1", 32'({out_valid1, in_ready1, ovf1, cout1, sum1}), 32'({2'b01, 2'b00, 16'h0}));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'({out_valid0, in_ready0}), 32'b01);

    // Pin the model itself.
    chk("model_add",  32'(ref_op(16'h1234, 16'h1111, 1'b0, 1'b0)), 32'h02345);
    chk("model_sub",  32'(ref_op(16'h0005, 16'h0007, 1'b0, 1'b1)), 32'h0FFFE);
    chk("model_ovf",  32'(ref_op(16'h8000, 16'h8000, 1'b0, 1'b0)), 32'h30000);

    directed(1'b0, 16'h1234, 16'h1111, 1'b0, 1'b0, 18'h02345);
    directed(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h10000);
    directed(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h28000);
    directed(1'b0, 16'h8000, 16'h8000, 1'b0, 1'b0, 18'h30000);
    directed(1'b0, 16'h0005, 16'h0007, 1'b0, 1'b1, 18'h0FFFE);
    directed(1'b0, 16'h0009, 16'h0003, 1'b1, 1'b1, 18'h10005);

    // Backpressure with ignored in_valid pulses, then an ordinary op.
    do_op(1'b0, 16'hA5A5, 16'h1234, 1'b1, 1'b0, 5, 1'b0);
    do_op(1'b0, 16'h4000, 16'h4000, 1'b0, 1'b0, 0, 1'b0);
    // out_ready already high on entry to DONE.
    do_op(1'b0, 16'h0100, 16'h0200, 1'b1, 1'b1, 0, 1'b1);

    // Reset after two chunks of an operation.
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0;
    in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("partial_sum", 32'(sum0[7:0]), 32'h45);
    chk("mid_run", 32'({out_valid0, in_ready0}), 32'b00);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_state", 32'({out_valid0, in_ready0, ovf0, cout0, sum0}), 32'({2'b01, 2'b00, 16'h0}));
    @(negedge clk);
    rst_n = 1'b1;
    directed(1'b0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 18'h00100);

    repeat (40) begin
      do_op(1'b0, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Single-chunk instance.
    directed(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h28000);
    directed(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, 18'h0FFFE);
    repeat (20) begin
      do_op(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
